// File: rtl/fast_dct_stream.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fast_dct_stream                                                          |
// | Streaming 8x8 2-D DCT: row pass then column pass, one MAC per cycle.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fast_dct_stream #(
  parameter int WIN  = 9,
  parameter int WIM  = 16,
  parameter int WOUT = 12
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [WIN-1:0]  slave_tdata,
  input  logic            slave_tvalid,
  output logic            slave_tready,
  output logic [WOUT-1:0] master_tdata,
  output logic            master_tvalid,
  input  logic            master_tready,
  output logic            master_tlast
);

  localparam int ACC_W  = WIM + 16;
  localparam int PROD_W = WIM + 12;
  localparam logic [ACC_W-1:0] c_round = ACC_W'(1024);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    ROW   = 2'd1,
    COL   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t r_state, w_state_nxt;

  logic signed [WIN-1:0]  r_pix [64];
  logic signed [WIM-1:0]  r_tmp [64];
  logic signed [WOUT-1:0] r_out [64];
  logic [5:0]             r_in_cnt;
  logic [8:0]             r_mac_cnt;
  logic [5:0]             r_k;
  logic [ACC_W-1:0]       r_acc;

  logic [WIM-1:0]         w_opnd;
  logic signed [11:0]     w_coef;
  logic [PROD_W-1:0]      w_prod;
  logic [ACC_W-1:0]       w_sum;
  logic signed [ACC_W-1:0] w_rnd;
  logic [WIM-1:0]         w_sat_row;
  logic [WOUT-1:0]        w_sat_col;
  logic                   w_last_tap;

  // Cosine angle (2n+1)*u*pi/16 folded into the first quadrant of a 32-step circle.
  function automatic logic signed [11:0] f_coef(input logic [2:0] u, input logic [2:0] n);
    logic [4:0]         m;
    logic               neg;
    logic signed [11:0] mag;
    m = 5'({n, 1'b1}) * 5'(u);
    if (m > 5'd16) m = 5'd0 - m;
    neg = (m > 5'd8);
    if (neg) m = 5'd16 - m;
    case (m)
      5'd0:    mag = 12'sd1024;
      5'd1:    mag = 12'sd1004;
      5'd2:    mag = 12'sd946;
      5'd3:    mag = 12'sd851;
      5'd4:    mag = 12'sd724;
      5'd5:    mag = 12'sd569;
      5'd6:    mag = 12'sd392;
      5'd7:    mag = 12'sd200;
      default: mag = 12'sd0;
    endcase
    if (u == 3'd0) return 12'sd724;
    return neg ? -mag : mag;
  endfunction

  // ROW counter is {y,u,x}; COL counter is {u,v,y}.
  always_comb begin
    w_opnd = '0;
    if (r_state == COL) begin
      w_opnd = r_tmp[{r_mac_cnt[2:0], r_mac_cnt[8:6]}];
    end else begin
      w_opnd = {{(WIM-WIN){r_pix[{r_mac_cnt[8:6], r_mac_cnt[2:0]}][WIN-1]}},
                r_pix[{r_mac_cnt[8:6], r_mac_cnt[2:0]}]};
    end
  end

  assign w_coef     = f_coef(r_mac_cnt[5:3], r_mac_cnt[2:0]);
  assign w_prod     = {{12{w_opnd[WIM-1]}}, w_opnd} * {{WIM{w_coef[11]}}, w_coef};
  assign w_sum      = r_acc + {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};
  assign w_rnd      = $signed(w_sum + c_round) >>> 11;
  assign w_last_tap = (r_mac_cnt[2:0] == 3'd7);

  always_comb begin
    w_sat_row = w_rnd[WIM-1:0];
    if (!((&w_rnd[ACC_W-1:WIM-1]) || !(|w_rnd[ACC_W-1:WIM-1])))
      w_sat_row = w_rnd[ACC_W-1] ? {1'b1, {(WIM-1){1'b0}}} : {1'b0, {(WIM-1){1'b1}}};
    w_sat_col = w_rnd[WOUT-1:0];
    if (!((&w_rnd[ACC_W-1:WOUT-1]) || !(|w_rnd[ACC_W-1:WOUT-1])))
      w_sat_col = w_rnd[ACC_W-1] ? {1'b1, {(WOUT-1){1'b0}}} : {1'b0, {(WOUT-1){1'b1}}};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= LOAD;
      r_in_cnt  <= '0;
      r_mac_cnt <= '0;
      r_k       <= '0;
      r_acc     <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        LOAD:  if (slave_tvalid) r_in_cnt <= r_in_cnt + 6'd1;
        ROW, COL: begin
          r_mac_cnt <= r_mac_cnt + 9'd1;
          r_acc     <= w_last_tap ? '0 : w_sum;
        end
        DRAIN: if (master_tready) r_k <= r_k + 6'd1;
        default: ;
      endcase
    end
  end

  // Storage arrays need no reset: nothing reaches the output until a full block is computed.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (r_state == LOAD && slave_tvalid)
        r_pix[r_in_cnt] <= slave_tdata;
      if (r_state == ROW && w_last_tap)
        r_tmp[r_mac_cnt[8:3]] <= w_sat_row;
      if (r_state == COL && w_last_tap)
        r_out[{r_mac_cnt[5:3], r_mac_cnt[8:6]}] <= w_sat_col;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    slave_tready  = 1'b0;
    master_tvalid = 1'b0;
    master_tdata  = '0;
    master_tlast  = 1'b0;
    case (r_state)
      LOAD: begin
        slave_tready = 1'b1;
        if (slave_tvalid && r_in_cnt == 6'd63) w_state_nxt = ROW;
      end
      ROW:  if (r_mac_cnt == 9'd511) w_state_nxt = COL;
      COL:  if (r_mac_cnt == 9'd511) w_state_nxt = DRAIN;
      DRAIN: begin
        master_tvalid = 1'b1;
        master_tdata  = r_out[r_k];
        master_tlast  = (r_k == 6'd63);
        if (master_tready && r_k == 6'd63) w_state_nxt = LOAD;
      end
      default: w_state_nxt = LOAD;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_fast_dct_stream.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fast_dct_stream                                                       |
// | Self-checking bench: integer DCT model, per-cycle handshake/data checks. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_fast_dct_stream;

  localparam int WIN = 9;
  localparam int WIM = 16;
  localparam int WOUT = 12;
  localparam int WOUT8 = 8;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [WIN-1:0]   slave_tdata = '0;
  logic             slave_tvalid = 1'b0;
  logic             master_tready = 1'b1;
  logic             slave_tready, master_tvalid, master_tlast;
  logic [WOUT-1:0]  master_tdata;
  logic             slave_tready8, master_tvalid8, master_tlast8;
  logic [WOUT8-1:0] master_tdata8;

  always #5 clock = ~clock;

  fast_dct_stream #(.WIN(WIN), .WIM(WIM), .WOUT(WOUT)) dut (
    .clock(clock), .reset(reset),
    .slave_tdata(slave_tdata), .slave_tvalid(slave_tvalid), .slave_tready(slave_tready),
    .master_tdata(master_tdata), .master_tvalid(master_tvalid),
    .master_tready(master_tready), .master_tlast(master_tlast)
  );

  fast_dct_stream #(.WIN(WIN), .WIM(WIM), .WOUT(WOUT8)) dut8 (
    .clock(clock), .reset(reset),
    .slave_tdata(slave_tdata), .slave_tvalid(slave_tvalid), .slave_tready(slave_tready8),
    .master_tdata(master_tdata8), .master_tvalid(master_tvalid8),
    .master_tready(master_tready), .master_tlast(master_tlast8)
  );

  int  n_tests = 0;
  int  n_fail = 0;
  int  c_tab [8][8];
  int  pix_buf [64];
  int  pix_n = 0;
  int  exp12_q [$];
  int  exp8_q [$];
  int  pin12 [12][64];
  int  pin8 [12][64];
  int  blk_cnt = 0;
  int  n_hs = 0;
  int  cyc = 0;
  bit  busy = 1'b0;
  bit  chk_en = 1'b0;
  bit  bp_mode = 1'b0;

  task automatic check(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic finish_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  endtask

  function automatic longint sat(input longint v, input int w);
    longint hi, lo;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -hi - 1;
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  // Reference 2-D DCT straight from the integer definition.
  task automatic model_block();
    longint t [8][8];
    longint acc, r;
    for (int y = 0; y < 8; y++)
      for (int u = 0; u < 8; u++) begin
        acc = 0;
        for (int x = 0; x < 8; x++) acc += longint'(pix_buf[8*y+x]) * c_tab[u][x];
        t[y][u] = sat((acc + 1024) >>> 11, WIM);
      end
    for (int v = 0; v < 8; v++)
      for (int u = 0; u < 8; u++) begin
        acc = 0;
        for (int y = 0; y < 8; y++) acc += t[y][u] * c_tab[v][y];
        r = (acc + 1024) >>> 11;
        if (blk_cnt < 12) begin
          pin12[blk_cnt][8*v+u] = int'(sat(r, WOUT));
          pin8[blk_cnt][8*v+u]  = int'(sat(r, WOUT8));
        end
        exp12_q.push_back(int'(sat(r, WOUT)));
        exp8_q.push_back(int'(sat(r, WOUT8)));
      end
    blk_cnt++;
  endtask

  // Check outputs against the model, then advance the model by the coming edge.
  always @(negedge clock) begin
    bit ev;
    if (chk_en) begin
      ev = busy && (cyc >= 1024);
      check("slave_tready", slave_tready, !busy);
      check("slave_tready8", slave_tready8, !busy);
      check("master_tvalid", master_tvalid, ev);
      check("master_tvalid8", master_tvalid8, ev);
      if (ev && exp12_q.size() > 0) begin
        check("tdata", $signed(master_tdata), exp12_q[0]);
        check("tdata8", $signed(master_tdata8), exp8_q[0]);
        check("tlast", master_tlast, exp12_q.size() == 1);
        check("tlast8", master_tlast8, exp8_q.size() == 1);
      end else begin
        check("tdata_idle", master_tdata, 0);
        check("tdata8_idle", master_tdata8, 0);
        check("tlast_idle", master_tlast, 0);
        check("tlast8_idle", master_tlast8, 0);
      end
    end
    if (reset) begin
      busy = 1'b0; pix_n = 0; cyc = 0;
      exp12_q.delete(); exp8_q.delete();
      chk_en = 1'b1;
    end else if (!busy) begin
      if (slave_tvalid) begin
        pix_buf[pix_n] = int'($signed(slave_tdata));
        pix_n++;
        if (pix_n == 64) begin
          model_block();
          pix_n = 0; busy = 1'b1; cyc = 0;
        end
      end
    end else if (cyc >= 1024) begin
      if (master_tready) begin
        void'(exp12_q.pop_front());
        void'(exp8_q.pop_front());
        n_hs++;
        if (exp12_q.size() == 0) busy = 1'b0;
      end
    end else begin
      cyc++;
    end
  end

  initial begin
    forever begin
      @(posedge clock); #1;
      master_tready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic send_block(input int px [64], input int gap_pct);
    int  i = 0;
    int  guard = 0;
    bit  acc;
    while (i < 64) begin
      if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        slave_tvalid = 1'b0;
      end else begin
        slave_tvalid = 1'b1;
        slave_tdata  = WIN'(px[i]);
      end
      @(negedge clock);
      acc = slave_tvalid && slave_tready;
      @(posedge clock); #1;
      if (acc) i++;
      guard++;
      if (guard > 20000) begin
        check("input_accept_timeout", i, 64);
        finish_run();
      end
    end
  endtask

  task automatic wait_idle();
    int g = 0;
    while (busy && g < 4000) begin
      @(posedge clock); #1;
      g++;
    end
    check("drain_timeout", busy, 0);
  endtask

  int px [64];

  initial begin
    real a, cv;
    for (int u = 0; u < 8; u++)
      for (int n = 0; n < 8; n++) begin
        a  = (u == 0) ? $sqrt(1.0 / 8.0) : 0.5;
        cv = 2048.0 * a * $cos(real'((2*n+1)*u) * 3.14159265358979 / 16.0);
        c_tab[u][n] = (cv >= 0.0) ? $rtoi(cv + 0.5) : -$rtoi(-cv + 0.5);
      end

    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // Back-to-back directed blocks, slave_tvalid never dropped.
    for (int i = 0; i < 64; i++) px[i] = 100;
    send_block(px, 0);
    for (int i = 0; i < 64; i++) px[i] = (i == 0) ? 255 : 0;
    send_block(px, 0);
    for (int i = 0; i < 64; i++) px[i] = (((i / 8) + (i % 8)) % 2 == 0) ? 255 : -256;
    send_block(px, 0);
    for (int i = 0; i < 64; i++) px[i] = (((i / 8) + (i % 8)) % 2 == 0) ? -256 : 255;
    send_block(px, 0);
    slave_tvalid = 1'b0;
    wait_idle();

    // Random data with input gaps and output backpressure.
    bp_mode = 1'b1;
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 64; i++) px[i] = int'($urandom_range(0, 511)) - 256;
      send_block(px, 30);
    end
    slave_tvalid = 1'b0;
    wait_idle();

    // Abort a block in the column pass, then run a clean one.
    bp_mode = 1'b0;
    for (int i = 0; i < 64; i++) px[i] = int'($urandom_range(0, 511)) - 256;
    send_block(px, 0);
    slave_tvalid = 1'b0;
    repeat (700) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    for (int i = 0; i < 64; i++) px[i] = int'($urandom_range(0, 511)) - 256;
    send_block(px, 0);
    slave_tvalid = 1'b0;
    wait_idle();
    repeat (4) @(posedge clock);

    // Hand-computed values that pin the model.
    check("coef_c00", c_tab[0][0], 724);
    check("coef_c10", c_tab[1][0], 1004);
    check("coef_c73", c_tab[7][3], -1004);
    check("const_dc", pin12[0][0], 800);
    for (int k = 1; k < 64; k++) check("const_ac", pin12[0][k], 0);
    check("impulse_dc", pin12[1][0], 32);
    check("checker_77", pin12[2][63], 1678);
    check("checker_77_w8", pin8[2][63], 127);
    check("inv_checker_77", pin12[3][63], -1678);
    check("inv_checker_77_w8", pin8[3][63], -128);
    check("blocks_loaded", blk_cnt, 9);
    check("outputs_drained", n_hs, 8 * 64);
    finish_run();
  end

endmodule
`default_nettype wire
